conv_window_accumulator: RTL

//  Consumes the N (=9) per-tap products of a 3x3 convolution window. Reduces them

---
 rtl/conv_window_accumulator_if.sv | 43 ++++
 rtl/conv_window_accumulator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/conv_window_accumulator_if.sv
// Handshake bundle for conv_window_accumulator.
// The input side carries 9 products plus bias with valid/ready; the output
// side carries a saturated pixel with valid/ready. busy reports in-flight
// work. The slave modport is the accumulator; the master modport is the
// producer/consumer that drives it.
interface conv_window_accumulator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 9
);
    logic                             in_valid;
    logic                             in_ready;
    logic [N-1:0][DATA_WIDTH-1:0]     mult_result;
    logic [DATA_WIDTH-1:0]            bias;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_sat;
    logic                             busy;

    modport slave (
        input  in_valid,
        input  mult_result,
        input  bias,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat,
        output busy
    );

    modport master (
        output in_valid,
        output mult_result,
        output bias,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat,
        input  busy
    );
endinterface

// File: rtl/conv_window_accumulator.sv
// 3x3 convolution window accumulator.
// Takes the nine per-tap products of a window and reduces them through a
// three-stage registered adder tree. The window sums are accumulated over
// NUM_CH channel passes, with bias added on the first pass. Each finished
// pixel is saturated to DATA_WIDTH and presented with valid/ready.
// The whole pipeline freezes while a finished pixel waits on the consumer.
// Optional feature: define CONV_ACC_RELU_EN to clamp negative results to 0
// after saturation. out_sat still reports saturation only.
module conv_window_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 9,
    parameter int NUM_CH     = 4,
    parameter int ACC_WIDTH  = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    conv_window_accumulator_if.slave      bus
);
    localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EXT_W = ACC_WIDTH - DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);
    // Saturation bounds of a DATA_WIDTH signed value, in accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(EXT_W + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(EXT_W + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // Handshake control
    logic stall;
    logic adv;

    // Pipeline stage data and valid bits
    logic signed [ACC_WIDTH-1:0] s1_reg [N];
    logic signed [ACC_WIDTH-1:0] s2_reg [3];
    logic signed [ACC_WIDTH-1:0] s3_reg;
    logic                        s1_v_reg;
    logic                        s2_v_reg;
    logic                        s3_v_reg;

    // Accumulator state
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]            ch_cnt_reg;
    logic [CNT_W-1:0]            ch_cnt_next;
    logic                        complete;
    logic signed [ACC_WIDTH-1:0] bias_ext;

    // Output stage
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_sat_reg;
    logic [DATA_WIDTH-1:0] sat_data;
    logic                  sat_flag;
    logic [DATA_WIDTH-1:0] out_data_next;

    // A pending pixel that the consumer refuses freezes everything upstream.
    assign stall        = out_valid_reg & ~bus.out_ready;
    assign adv          = ~stall & ~rst;
    assign bus.in_ready = adv;

    assign bias_ext = {{EXT_W{bus.bias[DATA_WIDTH-1]}}, bus.bias};

    // Stage 1: capture the products, sign-extended to accumulator width.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_s1
            always_ff @(posedge clk) begin
                if (adv) begin
                    s1_reg[gi] <= {{EXT_W{bus.mult_result[gi][DATA_WIDTH-1]}},
                                   bus.mult_result[gi]};
                end
            end
        end
    endgenerate

    // Stage 2: one partial sum per row of the 3x3 window.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_s2
            always_ff @(posedge clk) begin
                if (adv) begin
                    s2_reg[gi] <= s1_reg[3*gi] + s1_reg[3*gi+1] + s1_reg[3*gi+2];
                end
            end
        end
    endgenerate

    // Stage 3: combine the three row sums into the window sum.
    always_ff @(posedge clk) begin
        if (adv) begin
            s3_reg <= s2_reg[0] + s2_reg[1] + s2_reg[2];
        end
    end

    // Stage valid bits; bubbles travel down the pipe as cleared bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_reg <= 1'b0;
            s2_v_reg <= 1'b0;
            s3_v_reg <= 1'b0;
        end else if (adv) begin
            s1_v_reg <= bus.in_valid;
            s2_v_reg <= s1_v_reg;
            s3_v_reg <= s2_v_reg;
        end
    end

    // Channel accumulation: pass 0 reloads with bias, later passes add on.
    always_comb begin
        acc_next    = acc_reg;
        ch_cnt_next = ch_cnt_reg;
        complete    = 1'b0;
        if (s3_v_reg) begin
            if (ch_cnt_reg == '0) begin
                acc_next = bias_ext + s3_reg;
            end else begin
                acc_next = acc_reg + s3_reg;
            end
            if (ch_cnt_reg == LAST_CH) begin
                ch_cnt_next = '0;
                complete    = 1'b1;
            end else begin
                ch_cnt_next = ch_cnt_reg + 1'b1;
            end
        end
    end

    // Clip the new accumulator value into the DATA_WIDTH signed range.
    always_comb begin
        sat_data = acc_next[DATA_WIDTH-1:0];
        sat_flag = 1'b0;
        if (acc_next > SAT_MAX) begin
            sat_data = SAT_MAX[DATA_WIDTH-1:0];
            sat_flag = 1'b1;
        end else if (acc_next < SAT_MIN) begin
            sat_data = SAT_MIN[DATA_WIDTH-1:0];
            sat_flag = 1'b1;
        end
    end

    // Optional rectification applied after saturation.
    always_comb begin
        out_data_next = sat_data;
`ifdef CONV_ACC_RELU_EN
        if (sat_data[DATA_WIDTH-1]) begin
            out_data_next = '0;
        end
`endif
    end

    // Accumulator, channel counter and output register. When advancing,
    // out_valid simply follows completion: either nothing was pending, or
    // the pending pixel is being taken on this same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg       <= '0;
            ch_cnt_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else if (adv) begin
            acc_reg       <= acc_next;
            ch_cnt_reg    <= ch_cnt_next;
            out_valid_reg <= complete;
            if (complete) begin
                out_data_reg <= out_data_next;
                out_sat_reg  <= sat_flag;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sat   = out_sat_reg;
    assign bus.busy      = s1_v_reg | s2_v_reg | s3_v_reg | (ch_cnt_reg != '0);

endmodule
